ball_control: RTL and testbench

BALL_CONTROL -- requirements
Module: ball_control

---
 rtl/ball_control_if.sv | 36 +++
 rtl/ball_control.sv | 205 ++++++++++++++++++++
 tb/tb_ball_control.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/ball_control_if.sv
// ball_control_if
// Groups the frame-level signals exchanged between the game-control FSM and
// the blocks around it.
//   frame_tick      : one-clk pulse per video frame
//   start           : one-clk pulse, begins a new game from GAME_OVER
//   ball_center_x/y : current ball position (10 bit) from the ball-position stage
//   paddle_left_y   : left paddle centre y (10 bit)
//   paddle_right_y  : right paddle centre y (10 bit)
//   cw_ballMovement : 4-bit move command to the ball-position stage
//   score_left/right: 4-bit point counters
//   game_over       : high while the game is over
// The slave modport is the view of ball_control; master is the driving side.
interface ball_control_if;
  logic       frame_tick;
  logic       start;
  logic [9:0] ball_center_x;
  logic [9:0] ball_center_y;
  logic [9:0] paddle_left_y;
  logic [9:0] paddle_right_y;
  logic [3:0] cw_ballMovement;
  logic [3:0] score_left;
  logic [3:0] score_right;
  logic       game_over;

  modport slave (
    input  frame_tick, start, ball_center_x, ball_center_y,
           paddle_left_y, paddle_right_y,
    output cw_ballMovement, score_left, score_right, game_over
  );

  modport master (
    output frame_tick, start, ball_center_x, ball_center_y,
           paddle_left_y, paddle_right_y,
    input  cw_ballMovement, score_left, score_right, game_over
  );
endinterface

// File: rtl/ball_control.sv
// ball_control
// Game-control FSM for a two-player paddle game. Once per frame_tick it decides
// how the ball moves (bounces off paddles and walls), detects misses, keeps
// score and handles serve delay and game over.
// Ports:
//   clk     : system clock, all state changes on its rising edge
//   reset_n : asynchronous active-low reset
//   bus     : ball_control_if.slave (frame_tick, start, ball/paddle
//             positions in; move command, scores, game_over out)
// Move command encoding: 0 hold, 1 (+x,+y), 2 (-x,-y), 3 (-x,+y),
// 4 (+x,-y), 5 recentre the ball.
module ball_control #(
  parameter int WIN_SCORE      = 7,
  parameter int SERVE_FRAMES   = 60,
  parameter int BALL_R         = 4,
  parameter int PADDLE_HALF_H  = 24,
  parameter int LEFT_PADDLE_X  = 20,
  parameter int RIGHT_PADDLE_X = 620
) (
  input  logic          clk,
  input  logic          reset_n,
  ball_control_if.slave bus
);

  localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

  localparam logic [9:0] MISS_LO    = 10'(BALL_R);
  localparam logic [9:0] MISS_HI    = 10'(639 - BALL_R);
  localparam logic [9:0] WALL_TOP   = 10'(BALL_R);
  localparam logic [9:0] WALL_BOT   = 10'(479 - BALL_R);
  localparam logic [9:0] LEFT_HIT   = 10'(LEFT_PADDLE_X + BALL_R);
  localparam logic [9:0] RIGHT_HIT  = 10'(RIGHT_PADDLE_X - BALL_R);
  localparam logic [9:0] HALF_H     = 10'(PADDLE_HALF_H);
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);

  localparam logic [3:0] CW_HOLD     = 4'b0000;
  localparam logic [3:0] CW_RECENTRE = 4'b0101;

  typedef enum logic [1:0] {SERVE, PLAY, SCORE, GAME_OVER} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] serveCnt_q, serveCnt_d;
  logic             dirX_q, dirX_d;
  logic             dirY_q, dirY_d;
  logic [3:0]       scoreLeft_q, scoreLeft_d;
  logic [3:0]       scoreRight_q, scoreRight_d;
  logic             scorerLeft_q, scorerLeft_d;
  logic [3:0]       cw_q, cw_d;

  logic             bounceDirX, bounceDirY;
  logic [3:0]       bumpedScore;

  // Unsigned distance between two coordinates, always larger minus smaller
  // so the result never wraps.
  function automatic logic [9:0] absDiff(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Direction pair to move command.
  function automatic logic [3:0] moveCode(input logic dx, input logic dy);
    logic [3:0] code;
    case ({dx, dy})
      2'b11:   code = 4'b0001;
      2'b00:   code = 4'b0010;
      2'b01:   code = 4'b0011;
      default: code = 4'b0100;
    endcase
    return code;
  endfunction

  // Directions after this frame's collisions. Paddle and wall checks are
  // independent so a corner hit flips both axes in the same tick. A paddle
  // only reflects a ball that is travelling toward it.
  always_comb begin
    bounceDirX = dirX_q;
    bounceDirY = dirY_q;
    if (!dirX_q && (bus.ball_center_x <= LEFT_HIT) &&
        (absDiff(bus.ball_center_y, bus.paddle_left_y) <= HALF_H)) begin
      bounceDirX = 1'b1;
    end else if (dirX_q && (bus.ball_center_x >= RIGHT_HIT) &&
                 (absDiff(bus.ball_center_y, bus.paddle_right_y) <= HALF_H)) begin
      bounceDirX = 1'b0;
    end
    if (bus.ball_center_y <= WALL_TOP) begin
      bounceDirY = 1'b1;
    end else if (bus.ball_center_y >= WALL_BOT) begin
      bounceDirY = 1'b0;
    end
  end

  // The scorer's counter plus one, held at WIN so it can never wrap.
  always_comb begin
    bumpedScore = scorerLeft_q ? scoreLeft_q : scoreRight_q;
    if (bumpedScore < WIN) begin
      bumpedScore = bumpedScore + 4'd1;
    end else begin
      bumpedScore = WIN;
    end
  end

  // Next-state logic. Every move command is registered, so the command for a
  // frame_tick appears on the cycle after the tick. A miss emits nothing on
  // its own tick; the recentre follows from the one-cycle SCORE state.
  always_comb begin
    state_d      = state_q;
    serveCnt_d   = serveCnt_q;
    dirX_d       = dirX_q;
    dirY_d       = dirY_q;
    scoreLeft_d  = scoreLeft_q;
    scoreRight_d = scoreRight_q;
    scorerLeft_d = scorerLeft_q;
    cw_d         = CW_HOLD;

    case (state_q)
      SERVE: begin
        if (bus.frame_tick) begin
          if (serveCnt_q == SERVE_LAST) begin
            serveCnt_d = '0;
            state_d    = PLAY;
          end else begin
            serveCnt_d = serveCnt_q + CNT_W'(1);
          end
        end
      end

      PLAY: begin
        if (bus.frame_tick) begin
          if (bus.ball_center_x <= MISS_LO) begin
            scorerLeft_d = 1'b0;
            state_d      = SCORE;
          end else if (bus.ball_center_x >= MISS_HI) begin
            scorerLeft_d = 1'b1;
            state_d      = SCORE;
          end else begin
            dirX_d = bounceDirX;
            dirY_d = bounceDirY;
            cw_d   = moveCode(bounceDirX, bounceDirY);
          end
        end
      end

      SCORE: begin
        // Serve heads toward the player who just conceded.
        cw_d       = CW_RECENTRE;
        serveCnt_d = '0;
        dirY_d     = 1'b1;
        if (scorerLeft_q) begin
          scoreLeft_d = bumpedScore;
          dirX_d      = 1'b1;
        end else begin
          scoreRight_d = bumpedScore;
          dirX_d       = 1'b0;
        end
        state_d = (bumpedScore == WIN) ? GAME_OVER : SERVE;
      end

      GAME_OVER: begin
        // start takes priority over any coincident frame_tick.
        if (bus.start) begin
          scoreLeft_d  = '0;
          scoreRight_d = '0;
          cw_d         = CW_RECENTRE;
          dirX_d       = 1'b1;
          dirY_d       = 1'b1;
          serveCnt_d   = '0;
          state_d      = SERVE;
        end
      end

      default: begin
        state_d = SERVE;
      end
    endcase
  end

  // State registers; reset also clears any move command still pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= SERVE;
      serveCnt_q   <= '0;
      dirX_q       <= 1'b1;
      dirY_q       <= 1'b1;
      scoreLeft_q  <= '0;
      scoreRight_q <= '0;
      scorerLeft_q <= 1'b0;
      cw_q         <= CW_HOLD;
    end else begin
      state_q      <= state_d;
      serveCnt_q   <= serveCnt_d;
      dirX_q       <= dirX_d;
      dirY_q       <= dirY_d;
      scoreLeft_q  <= scoreLeft_d;
      scoreRight_q <= scoreRight_d;
      scorerLeft_q <= scorerLeft_d;
      cw_q         <= cw_d;
    end
  end

  assign bus.cw_ballMovement = cw_q;
  assign bus.score_left      = scoreLeft_q;
  assign bus.score_right     = scoreRight_q;
  assign bus.game_over       = (state_q == GAME_OVER);

endmodule

// File: tb/tb_ball_control.sv
// tb_ball_control
// Directed bench for ball_control with default parameters. Walks through
// serve, wall/paddle/corner bounces, misses, scoring to game over, restart
// and an asynchronous reset in the middle of play.
module tb_ball_control;

  logic clk;
  logic reset_n;
  int   compared;
  int   mismatched;
  int   nonZero;

  ball_control_if bus();

  ball_control dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive one clock cycle of inputs; called at a falling edge, returns at
  // the next falling edge so outputs reflect the rising edge in between.
  task automatic applyStimulus(input logic tick, input logic st);
    bus.frame_tick = tick;
    bus.start      = st;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    bus.start      = 1'b0;
  endtask

  task automatic setBall(input int x, input int y);
    bus.ball_center_x = 10'(x);
    bus.ball_center_y = 10'(y);
  endtask

  // Sixty serve ticks with an idle cycle after each; counts any command seen.
  task automatic serveTicks(output int seen);
    seen = 0;
    setBall(320, 220);
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'b1, 1'b0);
      if (bus.cw_ballMovement !== 4'd0) seen++;
      applyStimulus(1'b0, 1'b0);
      if (bus.cw_ballMovement !== 4'd0) seen++;
    end
  endtask

  // One play tick, returning the resulting command.
  task automatic playTick(input int x, input int y, input string tag,
                          input int expected);
    setBall(x, y);
    applyStimulus(1'b1, 1'b0);
    checkOutput(tag, 32'(bus.cw_ballMovement), 32'(expected));
  endtask

  initial begin
    compared           = 0;
    mismatched         = 0;
    reset_n            = 1'b1;
    bus.frame_tick     = 1'b0;
    bus.start          = 1'b0;
    bus.paddle_left_y  = 10'd240;
    bus.paddle_right_y = 10'd240;
    setBall(320, 220);

    #1 reset_n = 1'b0;
    #20;
    checkOutput("reset_cw", 32'(bus.cw_ballMovement), 0);
    checkOutput("reset_score_left", 32'(bus.score_left), 0);
    checkOutput("reset_score_right", 32'(bus.score_right), 0);
    checkOutput("reset_game_over", 32'(bus.game_over), 0);

    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("first_cycle_no_move", 32'(bus.cw_ballMovement), 0);

    // Serve, then first move down-right for exactly one clock.
    serveTicks(nonZero);
    checkOutput("serve_quiet", 32'(nonZero), 0);
    playTick(320, 220, "first_move", 1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("move_one_clk", 32'(bus.cw_ballMovement), 0);

    // Walls and paddles; tracked direction noted per step.
    playTick(300, 475, "bottom_wall", 4);              // -> right, up
    playTick(300, 4, "top_wall", 1);                   // -> right, down
    bus.paddle_right_y = 10'd230;
    playTick(616, 240, "right_paddle", 3);             // -> left, down
    playTick(616, 240, "right_paddle_wrong_dir", 3);
    bus.paddle_left_y = 10'd210;
    playTick(24, 200, "left_paddle", 1);               // -> right, down
    bus.paddle_right_y = 10'd264;
    playTick(616, 240, "right_paddle_edge", 3);        // -> left, down
    bus.paddle_left_y = 10'd300;
    playTick(24, 200, "left_paddle_far", 3);
    bus.paddle_left_y = 10'd175;
    playTick(24, 200, "left_paddle_just_out", 3);
    bus.paddle_left_y = 10'd176;
    playTick(24, 200, "left_paddle_just_in", 1);       // -> right, down
    bus.paddle_right_y = 10'd470;
    playTick(616, 475, "right_corner", 2);             // -> left, up
    bus.paddle_left_y = 10'd20;
    playTick(24, 4, "left_corner", 1);                 // -> right, down
    bus.paddle_left_y = 10'd300;
    playTick(5, 200, "x5_not_miss", 1);

    // Right player scores on a left miss.
    playTick(4, 200, "miss_left_no_move", 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("score_recentre", 32'(bus.cw_ballMovement), 5);
    checkOutput("score_right_1", 32'(bus.score_right), 1);
    checkOutput("score_left_0", 32'(bus.score_left), 0);

    // start outside GAME_OVER has no effect.
    applyStimulus(1'b0, 1'b1);
    checkOutput("start_ignored_cw", 32'(bus.cw_ballMovement), 0);
    checkOutput("start_ignored_score", 32'(bus.score_right), 1);

    // Serve goes leftward toward the conceding left player.
    serveTicks(nonZero);
    checkOutput("serve2_quiet", 32'(nonZero), 0);
    bus.paddle_right_y = 10'd400;
    playTick(320, 220, "serve_leftward", 3);
    playTick(634, 100, "x634_not_miss", 3);
    playTick(635, 100, "miss_right_no_move", 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("score_left_1", 32'(bus.score_left), 1);

    // Left scores five more to reach six.
    nonZero = 0;
    for (int p = 0; p < 5; p++) begin
      int seen;
      serveTicks(seen);
      nonZero += seen;
      setBall(635, 100);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
    end
    checkOutput("serve_loop_quiet", 32'(nonZero), 0);
    checkOutput("score_left_6", 32'(bus.score_left), 6);
    checkOutput("not_over_at_6", 32'(bus.game_over), 0);

    // Winning point.
    serveTicks(nonZero);
    playTick(635, 100, "win_miss_no_move", 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("win_recentre", 32'(bus.cw_ballMovement), 5);
    checkOutput("score_left_7", 32'(bus.score_left), 7);
    checkOutput("game_over_set", 32'(bus.game_over), 1);

    // GAME_OVER is frozen.
    playTick(320, 220, "over_tick_quiet", 0);
    playTick(4, 200, "over_miss_quiet", 0);
    checkOutput("over_score_right", 32'(bus.score_right), 1);
    checkOutput("over_score_left", 32'(bus.score_left), 7);

    // start with coincident tick restarts.
    applyStimulus(1'b1, 1'b1);
    checkOutput("restart_cw", 32'(bus.cw_ballMovement), 5);
    checkOutput("restart_score_left", 32'(bus.score_left), 0);
    checkOutput("restart_score_right", 32'(bus.score_right), 0);
    checkOutput("restart_game_over", 32'(bus.game_over), 0);

    serveTicks(nonZero);
    checkOutput("serve3_quiet", 32'(nonZero), 0);
    playTick(320, 220, "restart_dir", 1);
    playTick(4, 200, "miss_after_restart", 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("score_right_again", 32'(bus.score_right), 1);
    serveTicks(nonZero);
    playTick(320, 220, "pre_reset_move", 3);

    // Asynchronous reset between clock edges.
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_cw", 32'(bus.cw_ballMovement), 0);
    checkOutput("async_score_right", 32'(bus.score_right), 0);
    checkOutput("async_score_left", 32'(bus.score_left), 0);
    checkOutput("async_game_over", 32'(bus.game_over), 0);
    @(negedge clk);
    reset_n = 1'b1;
    playTick(320, 220, "post_reset_serve", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
